// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
// Frame state encoding and frame geometry constants.
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE   = 2'd0;
    localparam ps2_state_t ST_DATA   = 2'd1;
    localparam ps2_state_t ST_PARITY = 2'd2;
    localparam ps2_state_t ST_STOP   = 2'd3;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 1 + PS2_DATA_BITS + 1 + 1;

endpackage

// File: rtl/ps2_rx_fifo_buf.sv
// Receive FIFO with first-word fall-through head output.
// Holds the last popped word on the output while empty.
module ps2_rx_fifo_buf
    import ps2_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_en_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] last_q;
    logic                  ovf_q;
    logic                  wr_ok, rd_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign rd_ok   = rd_en_i & ~empty_o;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign wr_ok   = wr_en_i & (~full_o | rd_en_i);

    // Net occupancy change for this cycle.
    always_comb begin
        count_d = count_q + {{(CW-1){1'b0}}, wr_ok}
                          - {{(CW-1){1'b0}}, rd_ok};
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy, held output word and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + 1'b1;
            if (rd_ok) begin
                rptr_q <= rptr_q + 1'b1;
                last_q <= mem_q[rptr_q];
            end
            count_q <= count_d;
            ovf_q   <= wr_en_i & full_o & ~rd_en_i;
        end
    end

    assign data_o     = empty_o ? last_q : mem_q[rptr_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a receive FIFO.
// Optional in-frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic                  clk_s1_q, clk_s2_q, clk_prev_q;
    logic                  dat_s1_q, dat_s2_q;
    logic                  fall;

    ps2_state_t            state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  push_q, push_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  tmo_hit;

    // Two-flop synchronizers plus a delayed clock copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;

    assign tmo_hit = ~fall && (state_q != ST_IDLE)
                   && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Cycles since the last falling edge while a frame is in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (fall || state_q == ST_IDLE || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Frame state machine; one bit consumed per falling edge.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        push_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_s2_q, shift_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            ferr_d  = 1'b1;
        end
    end

    // Frame state registers and one-cycle result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            push_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            push_q  <= push_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

    ps2_rx_fifo_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (reset_n),
        .wr_en_i    (push_q),
        .wr_data_i  (shift_q),
        .rd_en_i    (rd_en),
        .data_o     (data_out),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for the PS/2 receiver and its FIFO.
// Timeout scenario is built only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    localparam int HP = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       empty, full;
    logic [3:0] count;
    logic       parity_err, frame_err, overflow;

    int n_chk = 0;
    int n_err = 0;
    int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int exp_pe = 0, exp_fe = 0, exp_ov = 0;
    int model_cnt = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_pop = 8'h00;

    always #5 clk = ~clk;

    ps2_rx_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (parity_err) pe_cnt++;
        if (frame_err)  fe_cnt++;
        if (overflow)   ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_hp();
        repeat (HP) @(negedge clk);
    endtask

    // Drives the first nbits bits of a frame, then settles.
    task automatic send(input logic [7:0] d, input logic bad_par,
                        input logic stop, input int nbits);
        logic [PS2_FRAME_BITS-1:0] fr;
        fr = {stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_hp();
            ps2_clk = 1'b0;
            wait_hp();
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Good frame: scoreboard predicts push or overflow.
    task automatic send_good(input logic [7:0] d);
        if (model_cnt < 8) begin
            sb_q.push_back(d);
            model_cnt++;
        end else begin
            exp_ov++;
        end
        send(d, 1'b0, 1'b1, PS2_FRAME_BITS);
    endtask

    task automatic pop_check();
        logic [7:0] exp;
        check("pop_nonempty", empty, 1'b0);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check("pop_data", data_out, exp);
            last_pop = exp;
            model_cnt--;
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_perr"}, pe_cnt, exp_pe);
        check({tag, "_ferr"}, fe_cnt, exp_fe);
        check({tag, "_ovf"},  ov_cnt, exp_ov);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 0);
        check("rst_data", data_out, 8'h00);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        send_good(8'h1C);
        check("f1c_count", count, 1);
        check("f1c_empty", empty, 1'b0);
        check("f1c_data", data_out, 8'h1C);
        check_errs("f1c");
        pop_check();
        check("f1c_empty_after", empty, 1'b1);
        check("hold_last", data_out, last_pop);

        send(8'h1C, 1'b1, 1'b1, PS2_FRAME_BITS);
        exp_pe++;
        check_errs("par");
        check("par_empty", empty, 1'b1);

        send(8'hF0, 1'b1, 1'b0, PS2_FRAME_BITS);
        exp_fe++;
        check_errs("stop");
        check("stop_empty", empty, 1'b1);

        for (int i = 1; i <= 8; i++) begin
            send_good(8'(i));
            check("fill_count", count, i);
        end
        check("fill_full", full, 1'b1);
        check_errs("fill");
        send_good(8'h09);
        check_errs("ovf");
        check("ovf_count", count, 8);
        check("ovf_full", full, 1'b1);
        for (int i = 0; i < 8; i++) pop_check();
        check("drain_empty", empty, 1'b1);
        check("drain_full", full, 1'b0);
        check("drain_hold", data_out, 8'h08);

        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("rd_empty_count", count, 0);
        check("rd_empty_flag", empty, 1'b1);
        check("rd_empty_data", data_out, 8'h08);

        send_good(8'h33);
        send(8'hA5, 1'b0, 1'b1, 5);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_count", count, 0);
        check("mid_rst_full", full, 1'b0);
        sb_q.delete();
        model_cnt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_errs("mid_rst");
        send_good(8'h29);
        check("f29_count", count, 1);
        pop_check();
        check_errs("f29");

`ifdef PS2_RX_TIMEOUT_EN
        send(8'h05, 1'b0, 1'b1, 4);
        repeat (5100) @(negedge clk);
        exp_fe++;
        check_errs("tmo");
        check("tmo_empty", empty, 1'b1);
        send_good(8'h5A);
        check("f5a_count", count, 1);
        pop_check();
        check_errs("f5a");
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
